// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
//
// Holds the opcode/funct constants, the FSM state encoding, the latched
// instruction-class record and the output code points (ALU op, pc_src,
// reg_dst, alu_src_b, load/save options).
// Optional macro MC_CTRL_EXC_EN adds the EXC state and the exception
// vector pc_src code.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef MC_CTRL_EXC_EN
      , S_EXC
`endif
   } state_e;

   typedef enum logic [3:0] {
      C_NOP, C_RTYPE, C_ORI, C_LUI, C_ADDIU, C_LOAD, C_STORE,
      C_BEQ, C_BNE, C_J, C_JAL, C_JR
   } iclass_e;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_AND = 4'd4;
   localparam logic [3:0] ALU_LUI = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   localparam logic [2:0] PC_PLUS4  = 3'd0;
   localparam logic [2:0] PC_BRANCH = 3'd1;
   localparam logic [2:0] PC_J      = 3'd2;
   localparam logic [2:0] PC_JAL    = 3'd3;
   localparam logic [2:0] PC_JR     = 3'd4;
   localparam logic [2:0] PC_EXC    = 3'd5;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] SRC_B_RT  = 2'd0;
   localparam logic [1:0] SRC_B_IMM = 2'd1;
   localparam logic [1:0] SRC_B_4   = 2'd2;

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_B  = 3'd1;
   localparam logic [2:0] LD_BU = 3'd2;
   localparam logic [2:0] LD_H  = 3'd3;
   localparam logic [2:0] LD_HU = 3'd4;

   localparam logic [1:0] ST_W = 2'd0;
   localparam logic [1:0] ST_B = 2'd1;
   localparam logic [1:0] ST_H = 2'd2;

   // Everything EXEC/MEM/WB need about the instruction, latched in DECODE.
   typedef struct packed {
      iclass_e    iclass;
      logic [3:0] alu;
      logic       usigned;
      logic [2:0] load_opt;
      logic [1:0] save_opt;
   } dec_t;

   localparam dec_t DEC_NOP = '{iclass: C_NOP, alu: ALU_ADD, usigned: 1'b0,
                                load_opt: LD_W, save_opt: ST_W};

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational IR opcode/funct to instruction-class classifier
//
// Ports:
//   opcode   in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   iclass   out 4  iclass_e code; C_NOP for anything unsupported
//   alu_op   out 4  ALU operation used in EXEC
//   usigned  out 1  addu/subu/addiu
//   load_opt out 3  load width/sign option
//   save_opt out 2  store width option
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] iclass,
   output logic [3:0] alu_op,
   output logic       usigned,
   output logic [2:0] load_opt,
   output logic [1:0] save_opt
);

   iclass_e cls;

   always_comb begin
      cls      = C_NOP;
      alu_op   = ALU_ADD;
      usigned  = 1'b0;
      load_opt = LD_W;
      save_opt = ST_W;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls = C_RTYPE;
               FN_ADDU: begin cls = C_RTYPE; usigned = 1'b1; end
               FN_SUB:  begin cls = C_RTYPE; alu_op = ALU_SUB; end
               FN_SUBU: begin cls = C_RTYPE; alu_op = ALU_SUB; usigned = 1'b1; end
               FN_AND:  begin cls = C_RTYPE; alu_op = ALU_AND; end
               FN_OR:   begin cls = C_RTYPE; alu_op = ALU_OR; end
               FN_SLT:  begin cls = C_RTYPE; alu_op = ALU_SLT; end
               FN_JR:   cls = C_JR;
               default: cls = C_NOP;
            endcase
         end
         OP_J:     cls = C_J;
         OP_JAL:   cls = C_JAL;
         OP_BEQ:   begin cls = C_BEQ; alu_op = ALU_SUB; end
         OP_BNE:   begin cls = C_BNE; alu_op = ALU_SUB; end
         OP_ADDIU: begin cls = C_ADDIU; usigned = 1'b1; end
         OP_ORI:   begin cls = C_ORI; alu_op = ALU_OR; end
         OP_LUI:   begin cls = C_LUI; alu_op = ALU_LUI; end
         OP_LW:    cls = C_LOAD;
         OP_LB:    begin cls = C_LOAD; load_opt = LD_B; end
         OP_LBU:   begin cls = C_LOAD; load_opt = LD_BU; end
         OP_LH:    begin cls = C_LOAD; load_opt = LD_H; end
         OP_LHU:   begin cls = C_LOAD; load_opt = LD_HU; end
         OP_SW:    cls = C_STORE;
         OP_SB:    begin cls = C_STORE; save_opt = ST_B; end
         OP_SH:    begin cls = C_STORE; save_opt = ST_H; end
         default:  cls = C_NOP;
      endcase
   end

   assign iclass = cls;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst[31:0]          memory data bus; opcode/funct captured on FETCH handshake
//   mem_ready           memory completes the current request
//   alu_zero            ALU result is zero (branch resolution)
//   mem_req, mem_we     memory request / write
//   ir_write, pc_write  IR and PC load enables
//   pc_src[2:0]         next-PC select
//   reg_write, reg_dst  register-file write enable / destination select
//   mem_to_reg, se      writeback from memory / sign-extend immediate
//   alu_src_b, alu_control, usigned   ALU operand and operation
//   load_option, save_option          memory access width, valid in MEM
//   mem_err             one-cycle pulse when a memory request times out
//   exc_req             exception request (only with MC_CTRL_EXC_EN)
// Optional macro: MC_CTRL_EXC_EN (unknown instruction / MEM timeout trap via EXC).
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int WAIT_CNT_W  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           inst,
   input  logic                  mem_ready,
   input  logic                  alu_zero,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic [2:0]            pc_src,
   output logic                  reg_write,
   output logic [1:0]            reg_dst,
   output logic                  mem_to_reg,
   output logic                  se,
   output logic [1:0]            alu_src_b,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic [2:0]            load_option,
   output logic [1:0]            save_option,
   output logic                  usigned,
   output logic                  mem_err
`ifdef MC_CTRL_EXC_EN
   ,
   output logic                  exc_req
`endif
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

   state_e                state, state_d;
   logic [WAIT_CNT_W-1:0] cnt, cnt_d;
   logic [5:0]            ir_op, ir_funct;
   dec_t                  dec_q, dec_now;
   logic                  hit_timeout;

   logic [3:0] dec_iclass, dec_alu;
   logic       dec_uns;
   logic [2:0] dec_ld;
   logic [1:0] dec_st;

   // Only opcode and funct matter to control; the rest of the word goes to the datapath.
   logic unused_inst;
   assign unused_inst = ^inst[25:6];

   mc_decode u_decode (
      .opcode   (ir_op),
      .funct    (ir_funct),
      .iclass   (dec_iclass),
      .alu_op   (dec_alu),
      .usigned  (dec_uns),
      .load_opt (dec_ld),
      .save_opt (dec_st)
   );

   assign dec_now = '{iclass: iclass_e'(dec_iclass), alu: dec_alu, usigned: dec_uns,
                      load_opt: dec_ld, save_opt: dec_st};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         cnt      <= '0;
         dec_q    <= DEC_NOP;
         ir_op    <= '0;
         ir_funct <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (ir_write) begin
            ir_op    <= inst[31:26];
            ir_funct <= inst[5:0];
         end
         if (state == S_DECODE) dec_q <= dec_now;
      end
   end

   always_comb begin
      state_d     = state;
      cnt_d       = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_PLUS4;
      reg_write   = 1'b0;
      reg_dst     = RD_RT;
      mem_to_reg  = 1'b0;
      se          = 1'b0;
      alu_src_b   = SRC_B_RT;
      alu_control = ALU_CTRL_W'(ALU_ADD);
      load_option = LD_W;
      save_option = ST_W;
      usigned     = 1'b0;
      mem_err     = 1'b0;
`ifdef MC_CTRL_EXC_EN
      exc_req     = 1'b0;
`endif
      // Ready in the same cycle as the timeout count wins over the abort.
      hit_timeout = (cnt == TIMEOUT_CNT) && !mem_ready;

      case (state)
         S_FETCH: begin
            if (mem_ready) begin
               mem_req  = 1'b1;
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = PC_PLUS4;
               state_d  = S_DECODE;
            end else if (hit_timeout) begin
               mem_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               mem_req = 1'b1;
               cnt_d   = cnt + WAIT_CNT_W'(1);
            end
         end

         S_DECODE: begin
            case (dec_now.iclass)
               C_J: begin
                  pc_write = 1'b1;
                  pc_src   = PC_J;
                  state_d  = S_FETCH;
               end
               C_JAL: begin
                  pc_write  = 1'b1;
                  pc_src    = PC_JAL;
                  reg_write = 1'b1;
                  reg_dst   = RD_RA;
                  state_d   = S_FETCH;
               end
               C_JR: begin
                  pc_write = 1'b1;
                  pc_src   = PC_JR;
                  state_d  = S_FETCH;
               end
               C_NOP: begin
`ifdef MC_CTRL_EXC_EN
                  state_d = S_EXC;
`else
                  state_d = S_FETCH;
`endif
               end
               default: state_d = S_EXEC;
            endcase
         end

         S_EXEC: begin
            alu_control = ALU_CTRL_W'(dec_q.alu);
            usigned     = dec_q.usigned;
            case (dec_q.iclass)
               C_RTYPE: begin
                  alu_src_b = SRC_B_RT;
                  state_d   = S_WB;
               end
               C_ORI, C_LUI, C_ADDIU: begin
                  alu_src_b = SRC_B_IMM;
                  se        = (dec_q.iclass == C_ADDIU);
                  state_d   = S_WB;
               end
               C_LOAD, C_STORE: begin
                  alu_control = ALU_CTRL_W'(ALU_ADD);
                  alu_src_b   = SRC_B_IMM;
                  se          = 1'b1;
                  state_d     = S_MEM;
               end
               C_BEQ, C_BNE: begin
                  alu_control = ALU_CTRL_W'(ALU_SUB);
                  pc_src      = PC_BRANCH;
                  pc_write    = (dec_q.iclass == C_BEQ) ? alu_zero : !alu_zero;
                  state_d     = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end

         S_MEM: begin
            load_option = dec_q.load_opt;
            save_option = dec_q.save_opt;
            if (mem_ready) begin
               mem_req = 1'b1;
               mem_we  = (dec_q.iclass == C_STORE);
               state_d = (dec_q.iclass == C_LOAD) ? S_WB : S_FETCH;
            end else if (hit_timeout) begin
               // The PC already moved past this instruction, so it is simply dropped.
               mem_err = 1'b1;
`ifdef MC_CTRL_EXC_EN
               state_d = S_EXC;
`else
               state_d = S_FETCH;
`endif
            end else begin
               mem_req = 1'b1;
               mem_we  = (dec_q.iclass == C_STORE);
               cnt_d   = cnt + WAIT_CNT_W'(1);
            end
         end

         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (dec_q.iclass == C_RTYPE) ? RD_RD : RD_RT;
            mem_to_reg = (dec_q.iclass == C_LOAD);
            state_d    = S_FETCH;
         end

`ifdef MC_CTRL_EXC_EN
         S_EXC: begin
            exc_req  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_EXC;
            state_d  = S_FETCH;
         end
`endif

         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         pc_src      = PC_PLUS4;
         reg_write   = 1'b0;
         reg_dst     = RD_RT;
         mem_to_reg  = 1'b0;
         se          = 1'b0;
         alu_src_b   = SRC_B_RT;
         alu_control = '0;
         load_option = LD_W;
         save_option = ST_W;
         usigned     = 1'b0;
         mem_err     = 1'b0;
`ifdef MC_CTRL_EXC_EN
         exc_req     = 1'b0;
`endif
      end
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit, the successor to the single-cycle combinational decoder. A state machine sequences FETCH, DECODE, EXEC, MEM and WB over a shared datapath. Memory accesses use a req/ready handshake with a parametrised timeout. The instruction set adds bne, addiu, and/or/slt, and byte/half loads and stores.

Parameters:
ALU_CTRL_W, 4, width of alu_control.
WAIT_CNT_W, 4, width of the memory-wait counter.
MEM_TIMEOUT, 15, cycles of mem_req without mem_ready before abort; must be less than 2**WAIT_CNT_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst  in  32  instruction word from the memory data bus; sampled on the FETCH handshake
mem_ready  in  1  memory completes the current request
alu_zero  in  1  ALU result equals zero
mem_req  out  1  memory request
mem_we  out  1  memory write
ir_write  out  1  load IR from inst
pc_write  out  1  load PC
pc_src  out  3  0 = pc+4, 1 = branch target, 2 = j, 3 = jal, 4 = jr
reg_write  out  1  register-file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  1  writeback selects memory data
se  out  1  sign-extend the immediate
alu_src_b  out  2  0 = rt, 1 = imm, 2 = const 4
alu_control  out  ALU_CTRL_W  0 = ADD, 1 = SUB, 3 = OR, 4 = AND, 6 = LUI, 7 = SLT
load_option  out  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu
save_option  out  2  0 = sw, 1 = sb, 2 = sh
usigned  out  1  unsigned arithmetic (addu, subu, addiu)
mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: synchronous; state <= FETCH, wait counter <= 0, IR-class register <= NOP. While rst is high, every output is 0.
- Registered state: state, wait counter, and the decoded instruction class latched in DECODE. All outputs are combinational from these plus mem_ready and alu_zero.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE (1 cycle): classify IR and latch the class.
  - j: pc_write=1, pc_src=2, then FETCH.
  - jal: pc_write=1, pc_src=3, reg_write=1, reg_dst=2 (writes pc+4), then FETCH.
  - jr: pc_write=1, pc_src=4, then FETCH.
  - Unknown opcode: treated as NOP, then FETCH.
  - All other classes go to EXEC.
- EXEC (1 cycle):
  - R-type: alu_src_b=0, then WB.
  - ori/lui/addiu: alu_src_b=1; se=1 for addiu only; then WB.
  - Load/store: ALU=ADD, alu_src_b=1, se=1, then MEM.
  - beq/bne: ALU=SUB, pc_src=1. pc_write=alu_zero for beq, ~alu_zero for bne. Then FETCH.
- MEM: mem_req=1. mem_we=1 for stores; load_option/save_option are valid throughout MEM.
  - On mem_ready: loads go to WB, stores go to FETCH.
- WB (1 cycle): reg_write=1. reg_dst=1 for R-type, 0 otherwise. mem_to_reg=1 for loads.
- Latency in cycles with zero wait states: jump 2, branch 3, ALU 4, store 4, load 5. Each wait state adds 1.
- Wait counter:
  - Cleared on entry to FETCH or MEM, and on mem_ready.
  - Increments each cycle mem_req=1 && !mem_ready.
  - When the counter reaches MEM_TIMEOUT with no ready: mem_err=1 and mem_req=0 that cycle, then go to FETCH.
  - No PC/IR/register write occurs on the aborted access. The PC was already advanced, so an aborted MEM instruction is dropped.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready in the same cycle the counter hits MEM_TIMEOUT: ready wins, no error.
- rst mid-instruction: abandon immediately and restart at FETCH on the next cycle.

Optional Feature:
MC_CTRL_EXC_EN:
- Defined: an unknown opcode/funct in DECODE enters state EXC for 1 cycle. EXC drives output exc_req=1, pc_write=1, pc_src=5 (exception vector), then goes to FETCH. A MEM timeout also routes through EXC.
- Undefined: port exc_req is absent, unknown opcodes act as NOP, and pc_src never takes the value 5.

Decomposition:
- Package mc_ctrl_pkg:
  - opcode/funct constants
  - state encoding
  - ALU, pc_src, reg_dst, load/save option codes
- Sub-module mc_decode: purely combinational IR-to-class classifier, instantiated once and its result latched in DECODE.

Test Plan:
- Reset, then addu $3,$1,$2 with mem_ready tied 1 -> mem_req in cycle 1; reg_write=1, reg_dst=1 in cycle 4; back in FETCH in cycle 5.
- lb with mem_ready delayed 3 cycles in MEM -> load_option=1 held for 4 MEM cycles, then WB with mem_to_reg=1; total 8 cycles.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_write=1, pc_src=1 for beq; pc_write=0 for bne.
- jal -> in DECODE: pc_write=1, pc_src=3, reg_write=1, reg_dst=2; next cycle is FETCH.
- sw with mem_ready never asserted -> mem_err pulses after 15 waiting cycles, no reg_write, FETCH follows.
- rst asserted during MEM of lw -> all outputs 0 while rst is high; first cycle after release has mem_req=1, mem_we=0.
